seq_alu_mdu: RTL

- Multi-cycle execute unit with parametrised width, replacing the single-cycle combinational ALU.
- Performs RV base integer ops in 1 cycle, plus M-extension multiply (iterative shift-add) and divide (iterative restoring).
- Sits in the EX stage behind the decoder. Uses valid/ready handshakes on both sides so the pipeline can stall on long ops.

---
 rtl/seq_alu_mdu.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu_mdu.sv
// Multi-cycle EX-stage execute unit: single-cycle RV base ALU ops, iterative
// shift-add multiply and restoring divide, with valid/ready on both sides.
module seq_alu_mdu #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_md,
  input  logic [3:0]      alu_ctr,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less
);

  localparam int unsigned ShW      = $clog2(XLEN);
  localparam int unsigned CntW     = $clog2(XLEN + 1);
  localparam int unsigned MulIters = XLEN / MUL_BITS;
  localparam logic [CntW-1:0] MulLast = CntW'(MulIters - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              less_q, less_d;
  logic [2:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;       // running product
  logic [2*XLEN-1:0] mcand_q, mcand_d;   // extended multiplicand, shifted left per step
  logic [XLEN-1:0]   mplier_q, mplier_d; // multiplier bits (mul) or dividend/quotient (div)
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic [XLEN:0]     diff;
  logic              less_us, less_s, uns_cmp;
  logic [ShW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res;
  logic              a_sgn, b_sgn, dsgn, a_neg, b_neg, div_ovf;
  logic              accept;
  logic [2*XLEN-1:0] mul_sum;
  logic [XLEN:0]     trial;
  logic              qbit;
  logic [XLEN-1:0]   rem_n, quo_n;

  // Base ALU result and request decode, all from the live request inputs.
  always_comb begin
    diff    = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
    less_us = ~diff[XLEN];
    less_s  = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];
    shamt   = b[ShW-1:0];
    uns_cmp = is_md ? ((md_op == 3'b011) || (md_op[2] && md_op[0])) : (alu_ctr == 4'b1010);
    a_sgn   = !md_op[2] && (md_op[1:0] != 2'b11);
    b_sgn   = !md_op[2] && !md_op[1];
    dsgn    = md_op[2] && !md_op[0];
    a_neg   = dsgn && a[XLEN-1];
    b_neg   = dsgn && b[XLEN-1];
    div_ovf = dsgn && (a == MinVal) && (b == '1);
    alu_res = '0;
    case (alu_ctr)
      4'b0000:          alu_res = a + b;
      4'b1000:          alu_res = diff[XLEN-1:0];
      4'b0001, 4'b1001: alu_res = a << shamt;
      4'b0010:          alu_res = {{(XLEN-1){1'b0}}, less_s};
      4'b1010:          alu_res = {{(XLEN-1){1'b0}}, less_us};
      4'b0011, 4'b1011: alu_res = b;
      4'b0100, 4'b1100: alu_res = a ^ b;
      4'b0101:          alu_res = a >> shamt;
      4'b1101:          alu_res = $unsigned($signed(a) >>> shamt);
      4'b0110, 4'b1110: alu_res = a | b;
      4'b0111, 4'b1111: alu_res = a & b;
      default:          alu_res = '0;
    endcase
  end

  // Handshake, FSM next state, and one multiply/divide iteration.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    less_d   = less_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;

    in_ready = !rst && !flush && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    accept   = in_valid && in_ready;

    mul_sum = acc_q;
    for (int unsigned j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) mul_sum = mul_sum + (mcand_q << j);
    end

    // Restoring step: the shifted partial remainder is always < 2*divisor.
    trial = {rem_q, mplier_q[XLEN-1]} - {1'b0, dvsr_q};
    qbit  = ~trial[XLEN];
    rem_n = qbit ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], mplier_q[XLEN-1]};
    quo_n = {mplier_q[XLEN-2:0], qbit};

    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StMul: begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == MulLast) begin
            state_d  = StDone;
            result_d = (op_q[1:0] == 2'b00) ? mul_sum[XLEN-1:0] : mul_sum[2*XLEN-1:XLEN];
          end
        end
        StDiv: begin
          rem_d    = rem_n;
          mplier_d = quo_n;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == DivLast) begin
            state_d = StDone;
            if (op_q[1]) result_d = rneg_q ? -rem_n : rem_n;
            else         result_d = qneg_q ? -quo_n : quo_n;
          end
        end
        StDone: if (out_ready) state_d = StIdle;
        default: ;
      endcase

      if (accept) begin
        zero_d = (a == b);
        less_d = uns_cmp ? less_us : less_s;
        op_d   = md_op;
        cnt_d  = '0;
        if (!is_md) begin
          result_d = alu_res;
          state_d  = StDone;
        end else if (!md_op[2]) begin
          // A negative signed multiplier contributes -a * 2^XLEN; preload it.
          acc_d    = (b_sgn && b[XLEN-1]) ? {-a, {XLEN{1'b0}}} : '0;
          mcand_d  = {{XLEN{a_sgn && a[XLEN-1]}}, a};
          mplier_d = b;
          state_d  = StMul;
        end else if (b == '0) begin
          result_d = md_op[1] ? a : '1;
          state_d  = StDone;
        end else if (div_ovf) begin
          result_d = md_op[1] ? '0 : MinVal;
          state_d  = StDone;
        end else begin
          rem_d    = '0;
          mplier_d = a_neg ? -a : a;
          dvsr_d   = b_neg ? -b : b;
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          state_d  = StDiv;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      less_q   <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      less_q   <= less_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign less      = less_q;

endmodule
